// File: rtl/pipeline_run_controller_if.sv
// Command port of the pipeline run controller (debug/UART side).
// A command transfers on a rising edge where cmd_valid && cmd_ready; the master holds op/count stable while valid.
interface pipeline_run_controller_if #(
   parameter int STEP_W = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [STEP_W-1:0] cmd_count;

   modport master (output cmd_valid, cmd_op, cmd_count, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_count, output cmd_ready);
endinterface

// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer: drives the pipeline clock-enable and clear, drains
// the pipe after a halt instruction reaches IF, and counts enabled cycles.
module pipeline_run_controller #(
   parameter int CNT_W        = 32,
   parameter int STEP_W       = 16,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_run_controller_if.slave cmd,
   input  logic                 halt_instr,
   output logic                 pipe_en,
   output logic                 pipe_clr,
   output logic [1:0]           state,
   output logic                 halted,
   output logic                 done,
   output logic                 cmd_err,
   output logic [CNT_W-1:0]     cycle_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_STEP  = 2'b10,
      S_DRAIN = 2'b11
   } state_t;

   localparam logic [1:0] OP_RUN   = 2'b00;
   localparam logic [1:0] OP_STEP  = 2'b01;
   localparam logic [1:0] OP_HALT  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [STEP_W-1:0] REM_ONE   = STEP_W'(1);
   localparam logic [STEP_W-1:0] REM_DRAIN = STEP_W'(DRAIN_CYCLES);

   state_t            state_q, state_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic              pipe_en_q, pipe_en_d;
   logic              pipe_clr_q, pipe_clr_d;
   logic              halted_q, halted_d;
   logic              done_q, done_d;
   logic              cmd_err_q, cmd_err_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept;

   assign accept = cmd.cmd_valid && cmd_ready_q;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      halted_d   = halted_q;
      pipe_clr_d = 1'b0;
      done_d     = 1'b0;
      cmd_err_d  = 1'b0;
      cnt_d      = (pipe_en_q && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (cmd.cmd_op)
                  OP_RUN: begin
                     if (halted_q) cmd_err_d = 1'b1;
                     else          state_d   = S_RUN;
                  end
                  OP_STEP: begin
                     if (halted_q) begin
                        cmd_err_d = 1'b1;
                     end else if (cmd.cmd_count == '0) begin
                        done_d = 1'b1;
                     end else begin
                        state_d = S_STEP;
                        rem_d   = cmd.cmd_count;
                     end
                  end
                  OP_HALT: begin
                  end
                  OP_CLEAR: begin
                     pipe_clr_d = 1'b1;
                     cnt_d      = '0;
                     halted_d   = 1'b0;
                  end
                  default: begin
                  end
               endcase
            end
         end
         S_RUN, S_STEP: begin
            // An explicit HALT freezes the pipe in place and outranks a halt instruction.
            if (accept && (cmd.cmd_op == OP_HALT)) begin
               state_d = S_IDLE;
               rem_d   = '0;
               done_d  = 1'b1;
            end else begin
               if (accept) cmd_err_d = 1'b1;
               if (halt_instr && pipe_en_q) begin
                  state_d = S_DRAIN;
                  rem_d   = REM_DRAIN;
               end else if (state_q == S_STEP) begin
                  if (rem_q <= REM_ONE) begin
                     state_d = S_IDLE;
                     rem_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     rem_d = rem_q - 1'b1;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (rem_q <= REM_ONE) begin
               state_d  = S_IDLE;
               rem_d    = '0;
               halted_d = 1'b1;
               done_d   = 1'b1;
            end else begin
               rem_d = rem_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            rem_d   = '0;
         end
      endcase

      pipe_en_d   = (state_d != S_IDLE);
      cmd_ready_d = (state_d != S_DRAIN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         pipe_en_q   <= 1'b0;
         pipe_clr_q  <= 1'b0;
         halted_q    <= 1'b0;
         done_q      <= 1'b0;
         cmd_err_q   <= 1'b0;
         cmd_ready_q <= 1'b1;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         pipe_en_q   <= pipe_en_d;
         pipe_clr_q  <= pipe_clr_d;
         halted_q    <= halted_d;
         done_q      <= done_d;
         cmd_err_q   <= cmd_err_d;
         cmd_ready_q <= cmd_ready_d;
         cnt_q       <= cnt_d;
      end
   end

   assign cmd.cmd_ready = cmd_ready_q;
   assign pipe_en       = pipe_en_q;
   assign pipe_clr      = pipe_clr_q;
   assign state         = state_q;
   assign halted        = halted_q;
   assign done          = done_q;
   assign cmd_err       = cmd_err_q;
   assign cycle_count   = cnt_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: scenario tasks checked against a
// transaction-level model of enabled-cycle counts and the sticky halt flag.
module tb_pipeline_run_controller;

   logic        clk;
   logic        reset;
   logic        halt_instr;
   logic        o_pipe_en, o_pipe_clr, o_halted, o_done, o_cmd_err;
   logic [1:0]  o_state;
   logic [31:0] o_cnt;
   logic        n_pipe_en, n_pipe_clr, n_halted, n_done, n_cmd_err;
   logic [1:0]  n_state;
   logic [3:0]  o_cnt4;

   pipeline_run_controller_if #(.STEP_W(16)) aif ();
   pipeline_run_controller_if #(.STEP_W(16)) bif ();

   assign bif.cmd_valid = aif.cmd_valid;
   assign bif.cmd_op    = aif.cmd_op;
   assign bif.cmd_count = aif.cmd_count;

   pipeline_run_controller #(.CNT_W(32), .STEP_W(16), .DRAIN_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .cmd(aif.slave), .halt_instr(halt_instr),
      .pipe_en(o_pipe_en), .pipe_clr(o_pipe_clr), .state(o_state), .halted(o_halted),
      .done(o_done), .cmd_err(o_cmd_err), .cycle_count(o_cnt)
   );

   pipeline_run_controller #(.CNT_W(4), .STEP_W(16), .DRAIN_CYCLES(4)) dut4 (
      .clk(clk), .reset(reset), .cmd(bif.slave), .halt_instr(halt_instr),
      .pipe_en(n_pipe_en), .pipe_clr(n_pipe_clr), .state(n_state), .halted(n_halted),
      .done(n_done), .cmd_err(n_cmd_err), .cycle_count(o_cnt4)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec;
   int          n_err;
   // reference model: enabled cycles since the last clear/reset, and the sticky halt flag
   int          exp_count;
   bit          exp_halted;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   function automatic logic [3:0] sat4(input int v);
      return (v > 15) ? 4'hF : 4'(v);
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [15:0] cnt);
      int guard;
      guard = 0;
      aif.cmd_valid = 1'b1;
      aif.cmd_op    = op;
      aif.cmd_count = cnt;
      while (!aif.cmd_ready && guard < 200) begin
         tick();
         guard++;
      end
      if (guard >= 200) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: cmd_ready stayed %0b, required 1", aif.cmd_ready);
      end
      tick();
      aif.cmd_valid = 1'b0;
   endtask

   task automatic run_watch(input int halt_at, input int hcmd_at, input bit hold_clr,
                            input int budget, output int en, output int drn, output int rdy_drn);
      int guard;
      en = 0; drn = 0; rdy_drn = 0; guard = 0;
      while (o_state != 2'b00 && guard < budget) begin
         aif.cmd_valid = 1'b0;
         halt_instr    = 1'b0;
         if (o_pipe_en) en++;
         if (o_state == 2'b11) begin
            drn++;
            if (aif.cmd_ready) rdy_drn++;
            if (hold_clr) begin
               aif.cmd_valid = 1'b1;
               aif.cmd_op    = 2'b11;
            end
         end else begin
            if (en == halt_at) halt_instr = 1'b1;
            if (en == hcmd_at) begin
               aif.cmd_valid = 1'b1;
               aif.cmd_op    = 2'b10;
            end
         end
         tick();
         guard++;
      end
      halt_instr = 1'b0;
      if (!hold_clr) aif.cmd_valid = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      #3;
      n_vec++; if (o_state !== 2'b00) begin n_err++; $display("FAIL rst_state: got %0d want 0", o_state); end
      n_vec++; if (o_pipe_en !== 1'b0 || o_pipe_clr !== 1'b0) begin n_err++; $display("FAIL rst_en_clr: got %0b%0b want 00", o_pipe_en, o_pipe_clr); end
      n_vec++; if (o_halted !== 1'b0 || o_done !== 1'b0 || o_cmd_err !== 1'b0) begin n_err++; $display("FAIL rst_flags: got %0b%0b%0b want 000", o_halted, o_done, o_cmd_err); end
      n_vec++; if (o_cnt !== 32'd0 || o_cnt4 !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d/%0d want 0", o_cnt, o_cnt4); end
      #19 reset = 1'b1;
      tick();
      n_vec++; if (o_state !== 2'b00 || o_pipe_en !== 1'b0 || aif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release: state %0d en %0b rdy %0b want 0 0 1", o_state, o_pipe_en, aif.cmd_ready); end
   endtask

   task automatic test_clear();
      send_cmd(2'b11, 16'd0);
      exp_count = 0; exp_halted = 1'b0;
      n_vec++; if (o_pipe_clr !== 1'b1) begin n_err++; $display("FAIL clr_pulse: got %0b want 1", o_pipe_clr); end
      n_vec++; if (o_cnt !== 32'd0 || o_cnt4 !== 4'd0 || o_halted !== 1'b0) begin n_err++; $display("FAIL clr_state: cnt %0d halted %0b want 0 0", o_cnt, o_halted); end
      tick();
      n_vec++; if (o_pipe_clr !== 1'b0 || o_pipe_en !== 1'b0) begin n_err++; $display("FAIL clr_width: clr %0b en %0b want 0 0", o_pipe_clr, o_pipe_en); end
   endtask

   task automatic test_step(input int n);
      int en, drn, rdy;
      if (exp_halted) test_clear();
      send_cmd(2'b01, 16'(n));
      run_watch(0, 0, 1'b0, n + 10, en, drn, rdy);
      exp_count += n;
      exp_q.push_back(32'(exp_count));
      n_vec++; if (en !== n || drn !== 0) begin n_err++; $display("FAIL step_en: got %0d en/%0d drain want %0d/0", en, drn, n); end
      n_vec++; if (o_state !== 2'b00 || o_done !== 1'b1) begin n_err++; $display("FAIL step_done: state %0d done %0b want 0 1", o_state, o_done); end
      exp_v = exp_q.pop_front();
      n_vec++; if (o_cnt !== exp_v || o_cnt4 !== sat4(exp_count)) begin n_err++; $display("FAIL step_count: got %0d/%0d want %0d/%0d", o_cnt, o_cnt4, exp_v, sat4(exp_count)); end
      tick();
      n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL step_done_width: got %0b want 0", o_done); end
   endtask

   task automatic test_step_zero();
      send_cmd(2'b01, 16'd0);
      n_vec++; if (o_done !== 1'b1 || o_state !== 2'b00 || o_pipe_en !== 1'b0) begin n_err++; $display("FAIL step0: done %0b state %0d en %0b want 1 0 0", o_done, o_state, o_pipe_en); end
      tick();
      n_vec++; if (o_done !== 1'b0 || o_cnt !== 32'(exp_count)) begin n_err++; $display("FAIL step0_after: done %0b cnt %0d want 0 %0d", o_done, o_cnt, exp_count); end
   endtask

   task automatic test_run_halt_instr(input int k);
      int en, drn, rdy;
      if (exp_halted) test_clear();
      send_cmd(2'b00, 16'd0);
      run_watch(k, 0, 1'b0, k + 20, en, drn, rdy);
      exp_count += k + 4; exp_halted = 1'b1;
      n_vec++; if (en !== k + 4 || drn !== 4 || rdy !== 0) begin n_err++; $display("FAIL hinstr_cycles: en %0d drain %0d rdy %0d want %0d 4 0", en, drn, rdy, k + 4); end
      n_vec++; if (o_state !== 2'b00 || o_halted !== 1'b1 || o_done !== 1'b1) begin n_err++; $display("FAIL hinstr_end: state %0d halted %0b done %0b want 0 1 1", o_state, o_halted, o_done); end
      n_vec++; if (o_cnt !== 32'(exp_count) || o_cnt4 !== sat4(exp_count)) begin n_err++; $display("FAIL hinstr_count: got %0d/%0d want %0d", o_cnt, o_cnt4, exp_count); end
      tick();
   endtask

   task automatic test_halted_err();
      send_cmd(2'b00, 16'd0);
      n_vec++; if (o_cmd_err !== 1'b1 || o_pipe_en !== 1'b0) begin n_err++; $display("FAIL halted_run: err %0b en %0b want 1 0", o_cmd_err, o_pipe_en); end
      tick();
      n_vec++; if (o_cmd_err !== 1'b0 || o_pipe_en !== 1'b0) begin n_err++; $display("FAIL halted_run_after: err %0b en %0b want 0 0", o_cmd_err, o_pipe_en); end
      send_cmd(2'b01, 16'd5);
      n_vec++; if (o_cmd_err !== 1'b1 || o_state !== 2'b00) begin n_err++; $display("FAIL halted_step: err %0b state %0d want 1 0", o_cmd_err, o_state); end
      test_clear();
      send_cmd(2'b00, 16'd0);
      n_vec++; if (o_state !== 2'b01 || o_cmd_err !== 1'b0) begin n_err++; $display("FAIL run_after_clear: state %0d err %0b want 1 0", o_state, o_cmd_err); end
      send_cmd(2'b10, 16'd0);
      exp_count += 1;
      n_vec++; if (o_cnt !== 32'(exp_count) || o_pipe_en !== 1'b0) begin n_err++; $display("FAIL run_after_clear_cnt: cnt %0d en %0b want %0d 0", o_cnt, o_pipe_en, exp_count); end
      tick();
   endtask

   task automatic test_run_halt_cmd(input int m);
      int en, drn, rdy;
      if (exp_halted) test_clear();
      send_cmd(2'b00, 16'd0);
      run_watch(0, m, 1'b0, m + 10, en, drn, rdy);
      exp_count += m;
      n_vec++; if (en !== m || drn !== 0) begin n_err++; $display("FAIL hcmd_cycles: en %0d drain %0d want %0d 0", en, drn, m); end
      n_vec++; if (o_pipe_en !== 1'b0 || o_halted !== 1'b0 || o_done !== 1'b1) begin n_err++; $display("FAIL hcmd_end: en %0b halted %0b done %0b want 0 0 1", o_pipe_en, o_halted, o_done); end
      n_vec++; if (o_cnt !== 32'(exp_count) || o_cnt4 !== sat4(exp_count)) begin n_err++; $display("FAIL hcmd_count: got %0d/%0d want %0d/%0d", o_cnt, o_cnt4, exp_count, sat4(exp_count)); end
      tick();
   endtask

   task automatic test_busy_err();
      if (exp_halted) test_clear();
      send_cmd(2'b00, 16'd0);
      send_cmd(2'b01, 16'd3);
      n_vec++; if (o_cmd_err !== 1'b1 || o_state !== 2'b01) begin n_err++; $display("FAIL busy_err: err %0b state %0d want 1 1", o_cmd_err, o_state); end
      send_cmd(2'b10, 16'd0);
      exp_count += 2;
      n_vec++; if (o_cmd_err !== 1'b0 || o_state !== 2'b00 || o_cnt !== 32'(exp_count)) begin n_err++; $display("FAIL busy_halt: err %0b state %0d cnt %0d want 0 0 %0d", o_cmd_err, o_state, o_cnt, exp_count); end
      tick();
   endtask

   task automatic test_same_edge(input int k);
      int en, drn, rdy;
      if (exp_halted) test_clear();
      send_cmd(2'b00, 16'd0);
      run_watch(k, k, 1'b0, k + 20, en, drn, rdy);
      exp_count += k;
      n_vec++; if (en !== k || drn !== 0 || o_halted !== 1'b0 || o_done !== 1'b1) begin n_err++; $display("FAIL same_edge: en %0d drain %0d halted %0b done %0b want %0d 0 0 1", en, drn, o_halted, o_done, k); end
      tick();
   endtask

   task automatic test_step_drain(input int n, input int k);
      int en, drn, rdy;
      if (exp_halted) test_clear();
      send_cmd(2'b01, 16'(n));
      run_watch(k, 0, 1'b0, n + 20, en, drn, rdy);
      exp_count += k + 4; exp_halted = 1'b1;
      n_vec++; if (en !== k + 4 || drn !== 4 || o_halted !== 1'b1) begin n_err++; $display("FAIL step_drain: en %0d drain %0d halted %0b want %0d 4 1", en, drn, o_halted, k + 4); end
      n_vec++; if (o_cnt !== 32'(exp_count)) begin n_err++; $display("FAIL step_drain_cnt: got %0d want %0d", o_cnt, exp_count); end
      tick();
   endtask

   task automatic test_drain_ready(input int k);
      int en, drn, rdy;
      if (exp_halted) test_clear();
      send_cmd(2'b00, 16'd0);
      run_watch(k, 0, 1'b1, k + 20, en, drn, rdy);
      n_vec++; if (drn !== 4 || rdy !== 0 || o_pipe_clr !== 1'b0) begin n_err++; $display("FAIL drain_hold: drain %0d rdy %0d clr %0b want 4 0 0", drn, rdy, o_pipe_clr); end
      tick();
      aif.cmd_valid = 1'b0;
      exp_count = 0; exp_halted = 1'b0;
      n_vec++; if (o_pipe_clr !== 1'b1 || o_halted !== 1'b0 || o_cnt !== 32'd0) begin n_err++; $display("FAIL drain_accept: clr %0b halted %0b cnt %0d want 1 0 0", o_pipe_clr, o_halted, o_cnt); end
      tick();
   endtask

   task automatic test_back_to_back();
      repeat (6) begin
         case ($urandom_range(0, 2))
            0:       test_step($urandom_range(1, 30));
            1:       test_run_halt_cmd($urandom_range(1, 30));
            default: test_run_halt_instr($urandom_range(1, 20));
         endcase
      end
   endtask

   task automatic test_saturate();
      test_clear();
      test_run_halt_cmd(20);
      n_vec++; if (o_cnt4 !== 4'hF || o_cnt !== 32'd20) begin n_err++; $display("FAIL saturate: got %0d/%0d want 15/20", o_cnt4, o_cnt); end
   endtask

   task automatic test_reset_mid_step();
      int seen;
      if (exp_halted) test_clear();
      send_cmd(2'b01, 16'd100);
      repeat ($urandom_range(3, 30)) tick();
      #2 reset = 1'b0;
      #1;
      exp_count = 0; exp_halted = 1'b0;
      n_vec++; if (o_state !== 2'b00 || o_pipe_en !== 1'b0 || aif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_state: state %0d en %0b rdy %0b want 0 0 1", o_state, o_pipe_en, aif.cmd_ready); end
      n_vec++; if (o_done !== 1'b0 || o_cmd_err !== 1'b0 || o_halted !== 1'b0 || o_pipe_clr !== 1'b0) begin n_err++; $display("FAIL midrst_flags: done %0b err %0b halted %0b clr %0b want 0", o_done, o_cmd_err, o_halted, o_pipe_clr); end
      n_vec++; if (o_cnt !== 32'd0 || o_cnt4 !== 4'd0) begin n_err++; $display("FAIL midrst_count: got %0d/%0d want 0", o_cnt, o_cnt4); end
      @(negedge clk) reset = 1'b1;
      seen = 0;
      repeat (5) begin
         tick();
         if (o_done || o_pipe_en) seen++;
      end
      n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midrst_quiet: %0d active cycles want 0", seen); end
   endtask

   initial begin
      reset = 1'b0; halt_instr = 1'b0;
      aif.cmd_valid = 1'b0; aif.cmd_op = 2'b00; aif.cmd_count = 16'd0;
      n_vec = 0; n_err = 0; exp_count = 0; exp_halted = 1'b0;
      test_reset();
      test_step(3);
      repeat (3) test_step($urandom_range(1, 40));
      test_step_zero();
      test_run_halt_instr(10);
      test_halted_err();
      test_run_halt_cmd(7);
      test_busy_err();
      test_same_edge($urandom_range(1, 15));
      test_drain_ready($urandom_range(1, 12));
      test_step_drain(5, 5);
      test_step_drain(20, $urandom_range(1, 19));
      test_back_to_back();
      test_saturate();
      test_reset_mid_step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
